bus_cycle_ctrl: RTL and testbench

//  Bus interface sequencer for the t8086 core. Arbitrates between the prefetch

---
 rtl/t8086_bus_pkg.sv | 25 ++
 rtl/bus_req_arb.sv | 42 ++++
 rtl/bus_cycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/t8086_bus_pkg.sv
// Shared encodings for the t8086 bus sequencer: FSM state codes, T2-T4 status
// codes and the physical address width.
package t8086_bus_pkg;

  localparam int ADDR_W = 20;

  typedef logic [2:0] bus_state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_TW   = 3'd4;
  localparam logic [2:0] ST_T4   = 3'd5;
  localparam logic [2:0] ST_HOLD = 3'd6;

  localparam logic [1:0] EU_RD = 2'b00;
  localparam logic [1:0] EU_WR = 2'b01;
  localparam logic [1:0] PF    = 2'b10;

  function automatic logic [1:0] bus_code(input logic is_pf, input logic we);
    return is_pf ? PF : (we ? EU_WR : EU_RD);
  endfunction

endpackage

// File: rtl/bus_req_arb.sv
// PF/EU request arbiter: EU wins unless PF has waited through EU_BURST_MAX
// completed EU accesses. Decision is combinational; only the burst count is held.
module bus_req_arb #(
  parameter int EU_BURST_MAX = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic arb_en_i,
  input  logic pf_req_i,
  input  logic eu_req_i,
  input  logic eu_done_i,
  output logic pf_win_o,
  output logic eu_win_o
);

  localparam int CW = $clog2(EU_BURST_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;

  // The access finishing this cycle already counts toward the decision made now.
  always_comb begin
    cnt_eff = cnt_q;
    if (!pf_req_i) begin
      cnt_eff = '0;
    end else if (eu_done_i && cnt_q != CW'(EU_BURST_MAX)) begin
      cnt_eff = cnt_q + 1'b1;
    end
  end

  assign pf_win_o = arb_en_i && pf_req_i && (!eu_req_i || cnt_eff == CW'(EU_BURST_MAX));
  assign eu_win_o = arb_en_i && eu_req_i && !pf_win_o;
  assign cnt_d    = pf_win_o ? '0 : cnt_eff;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// t8086 bus sequencer: arbitrates PF/EU and runs T1..T4 cycles on the ad/as pads.
// Define T8086_HOLD_EN to add the hold/hlda bus-release handshake.
module bus_cycle_ctrl #(
  parameter int EU_BURST_MAX = 2,
  parameter int ADDR_W       = t8086_bus_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pf_req,
  input  logic [ADDR_W-1:0] pf_addr,
  output logic              pf_gnt,
  output logic              pf_valid,
  output logic [15:0]       pf_data,
  input  logic              eu_req,
  input  logic              eu_we,
  input  logic              eu_byte,
  input  logic [ADDR_W-1:0] eu_addr,
  input  logic [15:0]       eu_wdata,
  output logic              eu_gnt,
  output logic              eu_done,
  output logic [15:0]       eu_rdata,
  input  logic [15:0]       ad_in,
  output logic [15:0]       ad_out,
  output logic              ad_oe,
  output logic [3:0]        as_out,
  output logic              as_oe,
  output logic              ale,
  output logic              rd_n,
  output logic              wr_n,
  output logic              bhe_n,
  input  logic              ready
`ifdef T8086_HOLD_EN
  ,
  input  logic              hold,
  output logic              hlda
`endif
);
  import t8086_bus_pkg::*;

  bus_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [1:0]        code_q, code_d;
  logic              byte_q, byte_d;
  logic              split_q, split_d;
  logic              second_q, second_d;
  logic [15:0]       pf_data_q, pf_data_d;
  logic [15:0]       eu_rdata_q, eu_rdata_d;

  logic       hold_take, arb_en, win_pf, win_eu;
  logic       is_pf, is_wr, in_data, strobe;
  logic [7:0] lane;

`ifdef T8086_HOLD_EN
  assign hold_take = hold;
  assign hlda      = (state_q == ST_HOLD);
`else
  assign hold_take = 1'b0;
`endif

  // The second half of a split word continues without re-arbitration.
  assign arb_en = ((state_q == ST_IDLE) || (state_q == ST_T4 && !split_q)) && !hold_take;

  bus_req_arb #(.EU_BURST_MAX(EU_BURST_MAX)) u_arb (
    .clk_i     (clk),
    .rst_ni    (rst),
    .arb_en_i  (arb_en),
    .pf_req_i  (pf_req),
    .eu_req_i  (eu_req),
    .eu_done_i (eu_done),
    .pf_win_o  (win_pf),
    .eu_win_o  (win_eu)
  );

  assign lane = addr_q[0] ? ad_in[15:8] : ad_in[7:0];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    code_d     = code_q;
    byte_d     = byte_q;
    split_d    = split_q;
    second_d   = second_q;
    pf_data_d  = pf_data_q;
    eu_rdata_d = eu_rdata_q;
    case (state_q)
      ST_IDLE, ST_T4: begin
        if (state_q == ST_T4 && split_q) begin
          state_d  = ST_T1;
          addr_d   = addr_q + 1'b1;
          wdata_d  = {8'h00, wdata_q[15:8]};
          split_d  = 1'b0;
          second_d = 1'b1;
`ifdef T8086_HOLD_EN
        end else if (hold_take) begin
          state_d = ST_HOLD;
`endif
        end else if (win_pf) begin
          state_d  = ST_T1;
          addr_d   = pf_addr;
          code_d   = bus_code(1'b1, 1'b0);
          byte_d   = 1'b0;
          split_d  = 1'b0;
          second_d = 1'b0;
        end else if (win_eu) begin
          state_d  = ST_T1;
          addr_d   = eu_addr;
          wdata_d  = eu_wdata;
          code_d   = bus_code(1'b0, eu_we);
          byte_d   = eu_byte || eu_addr[0];
          split_d  = !eu_byte && eu_addr[0];
          second_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_T1: state_d = ST_T2;
      ST_T2: state_d = ST_T3;
      ST_T3, ST_TW: begin
        if (ready) begin
          state_d = ST_T4;
          if (code_q == PF) begin
            pf_data_d = ad_in;
          end else if (code_q == EU_RD) begin
            if (!byte_q)       eu_rdata_d = ad_in;
            else if (second_q) eu_rdata_d = {lane, eu_rdata_q[7:0]};
            else               eu_rdata_d = {8'h00, lane};
          end
        end else begin
          state_d = ST_TW;
        end
      end
`ifdef T8086_HOLD_EN
      ST_HOLD: if (!hold) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      code_q     <= EU_RD;
      byte_q     <= 1'b0;
      split_q    <= 1'b0;
      second_q   <= 1'b0;
      pf_data_q  <= '0;
      eu_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      code_q     <= code_d;
      byte_q     <= byte_d;
      split_q    <= split_d;
      second_q   <= second_d;
      pf_data_q  <= pf_data_d;
      eu_rdata_q <= eu_rdata_d;
    end
  end

  // Pad outputs decode straight from state so an async reset drops strobes at once.
  assign is_pf   = (code_q == PF);
  assign is_wr   = (code_q == EU_WR);
  assign in_data = (state_q == ST_T2) || (state_q == ST_T3) || (state_q == ST_TW) || (state_q == ST_T4);
  assign strobe  = (state_q == ST_T2) || (state_q == ST_T3) || (state_q == ST_TW);

  assign ale      = (state_q == ST_T1);
  assign pf_gnt   = ale && is_pf;
  assign eu_gnt   = ale && !is_pf && !second_q;
  assign pf_valid = (state_q == ST_T4) && is_pf;
  assign eu_done  = (state_q == ST_T4) && !is_pf && !split_q;
  assign pf_data  = pf_data_q;
  assign eu_rdata = eu_rdata_q;

  assign ad_oe  = ale || (in_data && is_wr);
  assign ad_out = ale ? addr_q[15:0] :
                  (in_data && is_wr) ? (byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q) :
                  16'h0000;
  assign as_out = ale ? addr_q[ADDR_W-1 -: 4] : (in_data ? {1'b0, 1'b1, code_q} : 4'h0);
  assign as_oe  = (state_q != ST_HOLD);
  assign rd_n   = !(strobe && !is_wr);
  assign wr_n   = !(strobe && is_wr);
  assign bhe_n  = !(ale && (!byte_q || addr_q[0]));

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: expected completions are queued when a
// request is issued and popped when pf_valid/eu_done fires.
module tb_bus_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pf_req;
  logic [19:0] pf_addr;
  logic        pf_gnt, pf_valid;
  logic [15:0] pf_data;
  logic        eu_req, eu_we, eu_byte;
  logic [19:0] eu_addr;
  logic [15:0] eu_wdata;
  logic        eu_gnt, eu_done;
  logic [15:0] eu_rdata;
  logic [15:0] ad_in, ad_out;
  logic        ad_oe;
  logic [3:0]  as_out;
  logic        as_oe, ale, rd_n, wr_n, bhe_n, ready;

  typedef struct packed {
    logic        is_pf;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  logic gnt_q[$];

  int checks = 0;
  int errors = 0;
  int n;
  logic exp_pf;

  always #5 clk = ~clk;

  bus_cycle_ctrl dut (
    .clk(clk), .rst(rst),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_gnt(pf_gnt), .pf_valid(pf_valid), .pf_data(pf_data),
    .eu_req(eu_req), .eu_we(eu_we), .eu_byte(eu_byte), .eu_addr(eu_addr), .eu_wdata(eu_wdata),
    .eu_gnt(eu_gnt), .eu_done(eu_done), .eu_rdata(eu_rdata),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .as_out(as_out), .as_oe(as_oe),
    .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .bhe_n(bhe_n), .ready(ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until a completion pulse (bounded), then pops and checks the scoreboard.
  task automatic wait_done(input string tag, input int max_ticks, output int cnt);
    exp_t e;
    cnt = 0;
    while (!(pf_valid || eu_done) && cnt < max_ticks) begin
      tick();
      cnt++;
    end
    chk({tag, "_seen"}, {31'd0, pf_valid || eu_done}, 32'd1);
    if ((pf_valid || eu_done) && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_kind"}, {31'd0, pf_valid}, {31'd0, e.is_pf});
      chk({tag, "_data"}, {16'd0, (pf_valid ? pf_data : eu_rdata)}, {16'd0, e.data});
    end
  endtask

  initial begin
    rst = 1'b0; pf_req = 1'b0; pf_addr = '0; eu_req = 1'b0; eu_we = 1'b0; eu_byte = 1'b0;
    eu_addr = '0; eu_wdata = '0; ad_in = '0; ready = 1'b1;
    tick(); tick();
    chk("rst_pins", {ad_oe, ad_out, as_out, ale, rd_n, wr_n, bhe_n, as_oe},
        {1'b0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
    chk("rst_flags", {pf_gnt, pf_valid, eu_gnt, eu_done}, 4'b0000);
    chk("rst_data", {pf_data, eu_rdata}, 32'h0);
    rst = 1'b1;
    tick();
    chk("idle_hold", {ale, rd_n, wr_n}, 3'b011);

    // PF read, ready high: four clocks T1..T4
    pf_req = 1'b1; pf_addr = 20'h0_0100; ad_in = 16'hBEEF;
    sb.push_back('{is_pf: 1'b1, data: 16'hBEEF});
    tick();
    chk("pf_t1", {ale, pf_gnt, eu_gnt, ad_oe, ad_out, as_out}, {4'b1101, 16'h0100, 4'h0});
    pf_req = 1'b0;
    tick();
    chk("pf_t2", {rd_n, ad_oe, as_out}, {1'b0, 1'b0, 4'h6});
    tick();
    chk("pf_t3", {31'd0, rd_n}, 32'd0);
    wait_done("pf", 4, n);
    chk("pf_len", n, 1);
    chk("pf_t4_rd", {31'd0, rd_n}, 32'd1);
    tick();
    chk("pf_idle", {ale, pf_valid}, 2'b00);

    // EU word write with three wait states
    eu_req = 1'b1; eu_we = 1'b1; eu_byte = 1'b0; eu_addr = 20'hA_0010; eu_wdata = 16'h1234;
    ready = 1'b0;
    sb.push_back('{is_pf: 1'b0, data: 16'h0000});
    tick();
    chk("wr_t1", {eu_gnt, ale, bhe_n, as_out, ad_out}, {3'b110, 4'hA, 16'h0010});
    eu_req = 1'b0;
    tick();
    chk("wr_t2", {wr_n, rd_n, ad_oe, as_out, ad_out}, {3'b011, 4'h5, 16'h1234});
    tick();
    chk("wr_t3", {31'd0, wr_n}, 32'd0);
    tick();
    chk("wr_tw1", {wr_n, ad_oe, ad_out}, {2'b01, 16'h1234});
    tick();
    chk("wr_tw2", {31'd0, wr_n}, 32'd0);
    tick();
    ready = 1'b1;
    chk("wr_tw3", {wr_n, eu_done, ad_out}, {2'b00, 16'h1234});
    wait_done("wr", 4, n);
    chk("wr_tw_count", n, 1);
    chk("wr_t4_strobe", {31'd0, wr_n}, 32'd1);
    tick();

    // EU byte read at odd address: high lane, zero-extended
    eu_req = 1'b1; eu_we = 1'b0; eu_byte = 1'b1; eu_addr = 20'h0_0021; ad_in = 16'h7700;
    sb.push_back('{is_pf: 1'b0, data: 16'h0077});
    tick();
    chk("brd_t1", {eu_gnt, bhe_n, ad_out}, {2'b10, 16'h0021});
    eu_req = 1'b0;
    wait_done("brd", 6, n);
    chk("brd_len", n, 3);
    tick();

    // EU word read at odd address splits into two byte cycles
    eu_req = 1'b1; eu_we = 1'b0; eu_byte = 1'b0; eu_addr = 20'h0_0033; ad_in = 16'h1100;
    sb.push_back('{is_pf: 1'b0, data: 16'h2211});
    tick();
    chk("split_t1a", {eu_gnt, bhe_n, ad_out}, {2'b10, 16'h0033});
    eu_req = 1'b0;
    tick(); tick(); tick();
    chk("split_no_early_done", {eu_done, rd_n}, 2'b01);
    ad_in = 16'h0022;
    tick();
    chk("split_t1b", {ale, eu_gnt, bhe_n, ad_out}, {3'b101, 16'h0034});
    wait_done("split", 6, n);
    chk("split_len", n, 3);
    tick();
    chk("split_single_done", {31'd0, eu_done}, 32'd0);

    // Both requesters held high: EU,EU,PF repeating, T4 straight to T1
    pf_req = 1'b1; pf_addr = 20'h0_0300;
    eu_req = 1'b1; eu_we = 1'b0; eu_byte = 1'b0; eu_addr = 20'h0_0200; ad_in = 16'h1357;
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
    for (int g = 0; g < 6; g++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!ale && n < 8);
      chk("arb_ale", {31'd0, ale}, 32'd1);
      exp_pf = gnt_q.pop_front();
      chk("arb_order", {pf_gnt, eu_gnt}, {exp_pf, !exp_pf});
      if (g > 0) chk("arb_b2b", n, 4);
      if (g == 5) begin
        pf_req = 1'b0;
        eu_req = 1'b0;
      end
    end
    tick(); tick(); tick(); tick();
    chk("arb_idle", {ale, rd_n}, 2'b01);

    // Async reset during T2 of a write
    eu_req = 1'b1; eu_we = 1'b1; eu_byte = 1'b0; eu_addr = 20'h0_0040; eu_wdata = 16'h5555;
    tick();
    eu_req = 1'b0;
    tick();
    chk("rstw_t2", {wr_n, ad_oe}, 2'b01);
    rst = 1'b0;
    #1;
    chk("rstw_now", {wr_n, ad_oe, ale}, 3'b100);
    chk("rstw_data", {pf_data, eu_rdata}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("rstw_idle", {ale, rd_n, wr_n, ad_oe, as_out}, {4'b0110, 4'h0});
    pf_req = 1'b1; pf_addr = 20'h0_0500; ad_in = 16'hC0DE;
    sb.push_back('{is_pf: 1'b1, data: 16'hC0DE});
    tick();
    chk("rstw_pf_gnt", {pf_gnt, ad_out}, {1'b1, 16'h0500});
    pf_req = 1'b0;
    wait_done("rstw_pf", 6, n);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
